// File: rtl/mac_accum_lane_array.sv
// rtl/mac_accum_lane_array.sv - per-lane saturating accumulator array with start/done handshake
module mac_accum_lane_array #(
  parameter int IN_WIDTH   = 20,
  parameter int DATA_WIDTH = 25,
  parameter int VEC_LENGTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         num_terms,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [IN_WIDTH-1:0]   psum  [VEC_LENGTH],
  output logic signed [DATA_WIDTH-1:0] accum [VEC_LENGTH],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [VEC_LENGTH-1:0]        ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0] ACC_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                       state_q, state_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] accum_q [VEC_LENGTH];
  logic signed [DATA_WIDTH-1:0] accum_d [VEC_LENGTH];
  logic [VEC_LENGTH-1:0]        ovf_q, ovf_d;
  logic                         in_ready_q, out_valid_q, busy_q;

  logic                         beat;
  logic signed [DATA_WIDTH:0]   lane_sum [VEC_LENGTH];
  logic signed [DATA_WIDTH-1:0] lane_res [VEC_LENGTH];
  logic [VEC_LENGTH-1:0]        lane_sat;

  // in_ready_q is high only in ACCUM, so this is the accepted-beat strobe
  assign beat = in_valid && in_ready_q;

  // Per-lane add at one extra bit, then clamp when the top two bits disagree
  always_comb begin
    for (int i = 0; i < VEC_LENGTH; i++) begin
      lane_sum[i] = {accum_q[i][DATA_WIDTH-1], accum_q[i]}
                  + {{(DATA_WIDTH+1-IN_WIDTH){psum[i][IN_WIDTH-1]}}, psum[i]};
      lane_sat[i] = lane_sum[i][DATA_WIDTH] ^ lane_sum[i][DATA_WIDTH-1];
      if (!lane_sat[i]) begin
        lane_res[i] = lane_sum[i][DATA_WIDTH-1:0];
      end else if (lane_sum[i][DATA_WIDTH]) begin
        lane_res[i] = ACC_MIN;
      end else begin
        lane_res[i] = ACC_MAX;
      end
    end
  end

  // Next-state, counter, accumulator and sticky overflow computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      accum_d[i] = accum_q[i];
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < VEC_LENGTH; i++) begin
            accum_d[i] = '0;
          end
          ovf_d = '0;
          if (num_terms != '0) begin
            cnt_d   = num_terms;
            state_d = ACCUM;
          end else begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          for (int i = 0; i < VEC_LENGTH; i++) begin
            accum_d[i] = lane_res[i];
          end
          ovf_d = ovf_q | lane_sat;
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // a concurrent start is deliberately dropped here
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovf_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < VEC_LENGTH; i++) begin
        accum_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == ACCUM);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      for (int i = 0; i < VEC_LENGTH; i++) begin
        accum_q[i] <= accum_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign accum     = accum_q;

endmodule

// File: tb/tb_mac_accum_lane_array.sv
// tb/tb_mac_accum_lane_array.sv - scoreboard bench for mac_accum_lane_array
module tb_mac_accum_lane_array;
  localparam int IW = 20;
  localparam int DW = 25;
  localparam int VL = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_terms = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, busy;
  logic signed [IW-1:0] psum  [VL];
  logic signed [DW-1:0] accum [VL];
  logic [VL-1:0]        ovf;

  typedef struct packed {
    logic [VL-1:0]         ovf;
    logic [VL-1:0][DW-1:0] acc;
  } res_t;

  res_t exp_q[$];
  res_t cur;
  bit   have_cur = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mac_accum_lane_array #(
    .IN_WIDTH(IW), .DATA_WIDTH(DW), .VEC_LENGTH(VL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
    .in_valid(in_valid), .in_ready(in_ready), .psum(psum), .accum(accum),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void expect_res(input longint a0, input longint a1,
                                     input longint a2, input longint a3,
                                     input logic [VL-1:0] o);
    res_t r;
    r.ovf    = o;
    r.acc[0] = DW'(a0);
    r.acc[1] = DW'(a1);
    r.acc[2] = DW'(a2);
    r.acc[3] = DW'(a3);
    exp_q.push_back(r);
  endfunction

  // Monitor: pop on the first valid cycle of a result, then re-check every held cycle
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!have_cur) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur) begin
        for (int i = 0; i < VL; i++) begin
          chk($sformatf("res_lane%0d", i), accum[i], $signed(cur.acc[i]));
        end
        chk("res_ovf", ovf, cur.ovf);
        if (out_ready) have_cur = 1'b0;
      end
    end
  end

  task automatic do_start(input int n);
    num_terms = CW'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic beat(input longint p0, input longint p1, input longint p2, input longint p3);
    int n;
    psum[0]  = IW'(p0);
    psum[1]  = IW'(p1);
    psum[2]  = IW'(p2);
    psum[3]  = IW'(p3);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic bubble(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic take_result(input int hold);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("result_valid", out_valid, 1);
    if (hold > 0) bubble(hold);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_handshake", busy, 0);
    chk("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < VL; i++) psum[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_accum0", accum[0], 0);

    // basic back-to-back
    expect_res(10, 21, 32, 43, 4'b0000);
    do_start(3);
    chk("basic_busy", busy, 1);
    beat(1, 2, 3, 4);
    beat(10, 20, 30, 40);
    beat(-1, -1, -1, -1);
    chk("basic_latency", out_valid, 1);
    take_result(0);

    // bubbles and 5 cycles of backpressure
    expect_res(10, 21, 32, 43, 4'b0000);
    do_start(3);
    beat(1, 2, 3, 4);
    bubble(2);
    beat(10, 20, 30, 40);
    bubble(2);
    beat(-1, -1, -1, -1);
    chk("bubble_latency", out_valid, 1);
    take_result(5);
    chk("idle_hold_accum1", accum[1], 21);

    // saturation on lanes 0 and 1
    expect_res(16777215, -16777216, 0, 0, 4'b0011);
    do_start(40);
    for (int k = 0; k < 40; k++) beat(524287, -524288, 0, 0);
    take_result(0);
    chk("ovf_held_idle", ovf, 3);
    expect_res(0, 0, 0, 0, 4'b0000);
    do_start(1);
    chk("ovf_cleared_by_start", ovf, 0);
    beat(0, 0, 0, 0);
    take_result(0);

    // zero terms
    expect_res(0, 0, 0, 0, 4'b0000);
    do_start(0);
    chk("zero_done_next", out_valid, 1);
    chk("zero_no_ready", in_ready, 0);
    take_result(1);

    // reset mid-operation
    do_start(4);
    beat(7, 7, 7, 7);
    beat(7, 7, 7, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_accum0", accum[0], 0);
    chk("async_rst_accum3", accum[3], 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_res(5, 5, 5, 5, 4'b0000);
    do_start(1);
    beat(5, 5, 5, 5);
    take_result(0);

    // start ignored in ACCUM and DONE; start dropped alongside out_ready
    expect_res(10, 21, 32, 43, 4'b0000);
    do_start(3);
    beat(1, 2, 3, 4);
    num_terms = CW'(7);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    chk("ign_accum_busy", busy, 1);
    chk("ign_accum_no_done", out_valid, 0);
    beat(10, 20, 30, 40);
    beat(-1, -1, -1, -1);
    chk("ign_done_reached", out_valid, 1);
    num_terms = CW'(5);
    start     = 1'b1;
    @(posedge clk); #1;
    chk("ign_done_stays", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b0;
    chk("drop_start_idle", busy, 0);
    @(posedge clk); #1;
    chk("drop_start_still_idle", busy, 0);
    chk("drop_start_no_ready", in_ready, 0);

    bubble(2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
